// File: rtl/pixart_i2c_responder.sv
// rtl/pixart_i2c_responder.sv - PixArt IR camera I2C target emulator
// Oversamples SCL/SDA, strobes register writes, and answers reads with an extended-mode blob report.
module pixart_i2c_responder #(
  parameter logic [6:0] I2C_ADDR  = 7'h58,
  parameter int         NUM_BLOBS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic [9:0] x_in,
  input  logic [9:0] y_in,
  input  logic [3:0] size_in,
  input  logic       blob_valid,
  output logic       wr_strobe,
  output logic [7:0] wr_reg,
  output logic [7:0] wr_data,
  output logic       busy
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ADDR     = 3'd1;
  localparam logic [2:0] S_ADDR_ACK = 3'd2;
  localparam logic [2:0] S_WR_BYTE  = 3'd3;
  localparam logic [2:0] S_WR_ACK   = 3'd4;
  localparam logic [2:0] S_RD_BYTE  = 3'd5;
  localparam logic [2:0] S_RD_ACK   = 3'd6;
  localparam logic [2:0] S_IGNORE   = 3'd7;

  localparam logic [7:0] HEADER_BYTE = 8'h00;
  localparam logic [7:0] REPORT_LEN  = 8'(1 + 3 * NUM_BLOBS);

  logic       scl_meta, scl_cur, scl_prev;
  logic       sda_meta, sda_cur, sda_prev;
  logic [2:0] state;
  logic [3:0] bit_cnt;
  logic [7:0] shift;
  logic [7:0] tx_shift;
  logic [7:0] pointer;
  logic       first_byte;
  logic [7:0] rd_index;
  logic [9:0] snap_x, snap_y;
  logic [3:0] snap_size;
  logic       snap_valid;
  logic [7:0] report_byte;

  logic scl_rise, scl_fall, start_cond, stop_cond;

  assign scl_rise   = ~scl_prev & scl_cur;
  assign scl_fall   = scl_prev & ~scl_cur;
  // SCL must be high in both samples so an SDA edge next to an SCL edge is not a bus condition
  assign start_cond = scl_prev & scl_cur & sda_prev & ~sda_cur;
  assign stop_cond  = scl_prev & scl_cur & ~sda_prev & sda_cur;

  always_comb begin
    report_byte = 8'hFF;
    if (rd_index == 8'd0) begin
      report_byte = HEADER_BYTE;
    end else if (rd_index < REPORT_LEN && snap_valid) begin
      case (rd_index)
        8'd1:    report_byte = snap_x[7:0];
        8'd2:    report_byte = snap_y[7:0];
        8'd3:    report_byte = {snap_y[9:8], snap_x[9:8], snap_size};
        default: report_byte = 8'hFF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_meta   <= 1'b1;
      scl_cur    <= 1'b1;
      scl_prev   <= 1'b1;
      sda_meta   <= 1'b1;
      sda_cur    <= 1'b1;
      sda_prev   <= 1'b1;
      state      <= S_IDLE;
      bit_cnt    <= 4'd0;
      shift      <= 8'h00;
      tx_shift   <= 8'h00;
      pointer    <= 8'h00;
      first_byte <= 1'b0;
      rd_index   <= 8'h00;
      snap_x     <= 10'd0;
      snap_y     <= 10'd0;
      snap_size  <= 4'd0;
      snap_valid <= 1'b0;
      sda_oe     <= 1'b0;
      busy       <= 1'b0;
      wr_strobe  <= 1'b0;
      wr_reg     <= 8'h00;
      wr_data    <= 8'h00;
    end else begin
      scl_meta  <= scl_in;
      scl_cur   <= scl_meta;
      scl_prev  <= scl_cur;
      sda_meta  <= sda_in;
      sda_cur   <= sda_meta;
      sda_prev  <= sda_cur;
      wr_strobe <= 1'b0;

      if (start_cond) begin
        state   <= S_ADDR;
        bit_cnt <= 4'd0;
        sda_oe  <= 1'b0;
      end else if (stop_cond) begin
        state  <= S_IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          S_ADDR: begin
            if (scl_rise && bit_cnt != 4'd8) begin
              shift   <= {shift[6:0], sda_cur};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              if (shift[7:1] == I2C_ADDR) begin
                sda_oe <= 1'b1;
                busy   <= 1'b1;
                state  <= S_ADDR_ACK;
              end else begin
                state <= S_IGNORE;
              end
            end
          end
          S_ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt <= 4'd0;
              if (shift[0]) begin
                snap_x     <= x_in;
                snap_y     <= y_in;
                snap_size  <= size_in;
                snap_valid <= blob_valid;
                rd_index   <= 8'd0;
                tx_shift   <= HEADER_BYTE;
                sda_oe     <= ~HEADER_BYTE[7];
                state      <= S_RD_BYTE;
              end else begin
                sda_oe     <= 1'b0;
                first_byte <= 1'b1;
                state      <= S_WR_BYTE;
              end
            end
          end
          S_WR_BYTE: begin
            if (scl_rise && bit_cnt != 4'd8) begin
              shift   <= {shift[6:0], sda_cur};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              sda_oe <= 1'b1;
              state  <= S_WR_ACK;
              if (first_byte) begin
                pointer    <= shift;
                first_byte <= 1'b0;
              end else begin
                wr_strobe <= 1'b1;
                wr_reg    <= pointer;
                wr_data   <= shift;
                pointer   <= pointer + 8'd1;
              end
            end
          end
          S_WR_ACK: begin
            if (scl_fall) begin
              sda_oe  <= 1'b0;
              bit_cnt <= 4'd0;
              state   <= S_WR_BYTE;
            end
          end
          S_RD_BYTE: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd7) begin
                sda_oe <= 1'b0;
                state  <= S_RD_ACK;
              end else begin
                sda_oe   <= ~tx_shift[6];
                tx_shift <= {tx_shift[6:0], 1'b0};
                bit_cnt  <= bit_cnt + 4'd1;
              end
            end
          end
          S_RD_ACK: begin
            // NACK leaves the state before the next fall, so a fall here always follows an ACK
            if (scl_rise) begin
              if (sda_cur) begin
                state  <= S_IGNORE;
                sda_oe <= 1'b0;
              end else if (rd_index != 8'hFF) begin
                rd_index <= rd_index + 8'd1;
              end
            end else if (scl_fall) begin
              tx_shift <= report_byte;
              sda_oe   <= ~report_byte[7];
              bit_cnt  <= 4'd0;
              state    <= S_RD_BYTE;
            end
          end
          default: begin
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pixart_i2c_responder.sv
// tb/tb_pixart_i2c_responder.sv - directed bench for the PixArt I2C responder
// A bit-banged master drives the bus; SDA is the wired-AND of master and responder.
module tb_pixart_i2c_responder;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe;
  logic [9:0] x_in = 10'd0;
  logic [9:0] y_in = 10'd0;
  logic [3:0] size_in = 4'd0;
  logic       blob_valid = 1'b0;
  logic       wr_strobe;
  logic [7:0] wr_reg;
  logic [7:0] wr_data;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int strobe_count = 0;
  int oe_cycles = 0;
  int busy_cycles = 0;
  logic [7:0] log_reg [0:63];
  logic [7:0] log_data[0:63];

  assign sda_line = sda_m & ~sda_oe;

  pixart_i2c_responder dut (
    .clk       (clk),
    .reset     (reset),
    .scl_in    (scl_m),
    .sda_in    (sda_line),
    .sda_oe    (sda_oe),
    .x_in      (x_in),
    .y_in      (y_in),
    .size_in   (size_in),
    .blob_valid(blob_valid),
    .wr_strobe (wr_strobe),
    .wr_reg    (wr_reg),
    .wr_data   (wr_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_strobe) begin
      log_reg[strobe_count % 64]  <= wr_reg;
      log_data[strobe_count % 64] <= wr_data;
      strobe_count <= strobe_count + 1;
    end
    if (sda_oe) oe_cycles <= oe_cycles + 1;
    if (busy) busy_cycles <= busy_cycles + 1;
  end

  task automatic q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; q();
    scl_m = 1'b1; q();
    sda_m = 1'b0; q();
    scl_m = 1'b0; q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; q();
    scl_m = 1'b1; q();
    sda_m = 1'b1; q();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic acked);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; q();
      scl_m = 1'b1; q(); q();
      scl_m = 1'b0; q();
    end
    sda_m = 1'b1; q();
    scl_m = 1'b1; q();
    acked = (sda_line == 1'b0);
    q();
    scl_m = 1'b0; q();
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; q();
      scl_m = 1'b1; q();
      b[i] = sda_line;
      q();
      scl_m = 1'b0; q();
    end
    sda_m = nack; q();
    scl_m = 1'b1; q(); q();
    scl_m = 1'b0; q();
    sda_m = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (wr_strobe !== 1'b0) begin errors++; $display("FAIL reset_wr_strobe: got %b want 0", wr_strobe); end
    checks++; if (wr_reg !== 8'h00) begin errors++; $display("FAIL reset_wr_reg: got %h want 00", wr_reg); end
    checks++; if (wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data: got %h want 00", wr_data); end
    checks++; if (dut.pointer !== 8'h00) begin errors++; $display("FAIL reset_pointer: got %h want 00", dut.pointer); end
  endtask

  task automatic test_write_single();
    logic [7:0] bytes [3];
    logic acked;
    int base;
    bytes = '{8'hB0, 8'h30, 8'h01};
    base = strobe_count;
    i2c_start();
    for (int i = 0; i < 3; i++) begin
      send_byte(bytes[i], acked);
      checks++; if (acked !== 1'b1) begin errors++; $display("FAIL wr1_ack%0d: got %b want 1", i, acked); end
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr1_busy: got %b want 1", busy); end
    i2c_stop();
    checks++; if (strobe_count - base !== 1) begin errors++; $display("FAIL wr1_strobes: got %0d want 1", strobe_count - base); end
    checks++; if (log_reg[base % 64] !== 8'h30) begin errors++; $display("FAIL wr1_reg: got %h want 30", log_reg[base % 64]); end
    checks++; if (log_data[base % 64] !== 8'h01) begin errors++; $display("FAIL wr1_data: got %h want 01", log_data[base % 64]); end
    checks++; if (dut.pointer !== 8'h31) begin errors++; $display("FAIL wr1_pointer: got %h want 31", dut.pointer); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr1_busy_stop: got %b want 0", busy); end
  endtask

  task automatic test_write_wrap();
    logic [7:0] bytes [5];
    logic [7:0] exp_reg [3];
    logic [7:0] exp_data [3];
    logic acked;
    int base;
    bytes    = '{8'hB0, 8'hFE, 8'hAA, 8'hBB, 8'hCC};
    exp_reg  = '{8'hFE, 8'hFF, 8'h00};
    exp_data = '{8'hAA, 8'hBB, 8'hCC};
    base = strobe_count;
    i2c_start();
    for (int i = 0; i < 5; i++) begin
      send_byte(bytes[i], acked);
      checks++; if (acked !== 1'b1) begin errors++; $display("FAIL wrap_ack%0d: got %b want 1", i, acked); end
    end
    i2c_stop();
    checks++; if (strobe_count - base !== 3) begin errors++; $display("FAIL wrap_strobes: got %0d want 3", strobe_count - base); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (log_reg[(base + i) % 64] !== exp_reg[i] || log_data[(base + i) % 64] !== exp_data[i]) begin
        errors++;
        $display("FAIL wrap_strobe%0d: got %h/%h want %h/%h", i, log_reg[(base + i) % 64], log_data[(base + i) % 64], exp_reg[i], exp_data[i]);
      end
    end
    checks++; if (dut.pointer !== 8'h01) begin errors++; $display("FAIL wrap_pointer: got %h want 01", dut.pointer); end
  endtask

  task automatic test_read_report();
    logic [7:0] exp [14];
    logic [7:0] got;
    logic acked;
    exp = '{0: 8'h00, 1: 8'hA5, 2: 8'h7C, 3: 8'h63, default: 8'hFF};
    blob_valid = 1'b1; x_in = 10'h2A5; y_in = 10'h17C; size_in = 4'd3;
    i2c_start();
    send_byte(8'hB1, acked);
    checks++; if (acked !== 1'b1) begin errors++; $display("FAIL rd_ack_addr: got %b want 1", acked); end
    for (int i = 0; i < 14; i++) begin
      read_byte(i == 13, got);
      if (i == 1) begin
        x_in = 10'h000; y_in = 10'h3FF; size_in = 4'hF; blob_valid = 1'b0;
      end
      checks++; if (got !== exp[i]) begin errors++; $display("FAIL rd_byte%0d: got %h want %h", i, got, exp[i]); end
    end
    q();
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL rd_nack_release: got %b want 0", sda_oe); end
    i2c_stop();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_busy_stop: got %b want 0", busy); end
  endtask

  task automatic test_wrong_address();
    logic acked;
    int s0, o0, b0;
    s0 = strobe_count; o0 = oe_cycles; b0 = busy_cycles;
    i2c_start();
    send_byte(8'h84, acked);
    checks++; if (acked !== 1'b0) begin errors++; $display("FAIL nomatch_ack_addr: got %b want 0", acked); end
    send_byte(8'h12, acked);
    checks++; if (acked !== 1'b0) begin errors++; $display("FAIL nomatch_ack_data: got %b want 0", acked); end
    i2c_stop();
    q();
    checks++; if (oe_cycles - o0 !== 0) begin errors++; $display("FAIL nomatch_oe_cycles: got %0d want 0", oe_cycles - o0); end
    checks++; if (busy_cycles - b0 !== 0) begin errors++; $display("FAIL nomatch_busy_cycles: got %0d want 0", busy_cycles - b0); end
    checks++; if (strobe_count - s0 !== 0) begin errors++; $display("FAIL nomatch_strobes: got %0d want 0", strobe_count - s0); end
  endtask

  task automatic test_repeated_start();
    logic [7:0] exp [4];
    logic [7:0] got;
    logic acked;
    int s0;
    exp = '{8'h00, 8'hFF, 8'hFF, 8'hFF};
    s0 = strobe_count;
    blob_valid = 1'b0; x_in = 10'h155; y_in = 10'h0AA; size_in = 4'd5;
    i2c_start();
    send_byte(8'hB0, acked);
    checks++; if (acked !== 1'b1) begin errors++; $display("FAIL rs_ack_wr_addr: got %b want 1", acked); end
    send_byte(8'h37, acked);
    checks++; if (acked !== 1'b1) begin errors++; $display("FAIL rs_ack_reg: got %b want 1", acked); end
    i2c_start();
    send_byte(8'hB1, acked);
    checks++; if (acked !== 1'b1) begin errors++; $display("FAIL rs_ack_rd_addr: got %b want 1", acked); end
    for (int i = 0; i < 4; i++) begin
      read_byte(i == 3, got);
      checks++; if (got !== exp[i]) begin errors++; $display("FAIL rs_byte%0d: got %h want %h", i, got, exp[i]); end
    end
    i2c_stop();
    checks++; if (dut.pointer !== 8'h37) begin errors++; $display("FAIL rs_pointer: got %h want 37", dut.pointer); end
    checks++; if (strobe_count - s0 !== 0) begin errors++; $display("FAIL rs_strobes: got %0d want 0", strobe_count - s0); end
  endtask

  task automatic test_reset_mid_read();
    logic acked;
    int base;
    blob_valid = 1'b1; x_in = 10'h2A5; y_in = 10'h17C; size_in = 4'd3;
    i2c_start();
    send_byte(8'hB1, acked);
    checks++; if (sda_oe !== 1'b1) begin errors++; $display("FAIL rst_pre_oe: got %b want 1", sda_oe); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL rst_release: got %b want 0", sda_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    @(negedge clk);
    reset = 1'b0;
    q();
    base = strobe_count;
    i2c_start();
    send_byte(8'hB0, acked);
    checks++; if (acked !== 1'b1) begin errors++; $display("FAIL rst_after_ack_addr: got %b want 1", acked); end
    send_byte(8'h10, acked);
    send_byte(8'h55, acked);
    checks++; if (acked !== 1'b1) begin errors++; $display("FAIL rst_after_ack_data: got %b want 1", acked); end
    i2c_stop();
    checks++;
    if (strobe_count - base !== 1 || log_reg[base % 64] !== 8'h10 || log_data[base % 64] !== 8'h55) begin
      errors++;
      $display("FAIL rst_after_strobe: got n=%0d %h/%h want n=1 10/55", strobe_count - base, log_reg[base % 64], log_data[base % 64]);
    end
  endtask

  initial begin
    test_reset();
    test_write_single();
    test_write_wrap();
    test_read_report();
    test_wrong_address();
    test_repeated_start();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
